// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pc_unit: RV32I IF stage, PC register and bubble marker for ID.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [1:0]  PC_sel,
   input  logic        flush,
   input  logic [31:0] target_branch,
   input  logic [31:0] target_jal,
   input  logic [31:0] target_jalr,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        is_flushed,
   output logic        misalign_err,
   output logic [31:0] bad_target,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] c_SEL_SEQ    = 2'b00;
   localparam logic [1:0] c_SEL_BRANCH = 2'b01;
   localparam logic [1:0] c_SEL_JAL    = 2'b10;

   logic [31:0] r_pc;
   logic [31:0] r_fpc;
   logic        r_fvalid;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;
   logic        w_misaligned;

   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_target = w_pc_plus4;
      case (PC_sel)
         c_SEL_SEQ:    w_target = w_pc_plus4;
         c_SEL_BRANCH: w_target = target_branch;
         c_SEL_JAL:    w_target = target_jal;
         default:      w_target = target_jalr & 32'hFFFF_FFFE;
      endcase
   end

   assign w_misaligned = |w_target[1:0];

   assign imem_addr  = r_pc;
   assign imem_en    = ~rst & (~stall | flush);
   assign id_instr   = r_fvalid ? imem_rdata : NOP;
   assign id_pc      = r_fpc;
   assign id_pc4     = r_fpc + 32'd4;
   assign is_flushed = ~r_fvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_fpc        <= 32'd0;
         r_fvalid     <= 1'b0;
         misalign_err <= 1'b0;
         bad_target   <= 32'd0;
         fetch_count  <= 32'd0;
      end else if (flush) begin
         // The wrong-path slot becomes a bubble; it still carries its PC.
         r_fpc    <= r_pc;
         r_fvalid <= 1'b0;
         if (w_misaligned) begin
            r_pc         <= TRAP_PC;
            misalign_err <= 1'b1;
            if (!misalign_err) begin
               bad_target <= w_target;
            end
         end else begin
            r_pc <= w_target;
         end
      end else if (!stall) begin
         r_fpc    <= r_pc;
         r_fvalid <= 1'b1;
         r_pc     <= w_pc_plus4;
         if (r_fvalid) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_pc_unit: scoreboard bench with directed fetch/redirect vectors. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_pc_unit;

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  PC_sel = 2'b00;
   logic        flush = 1'b0;
   logic [31:0] target_branch = 32'd0;
   logic [31:0] target_jal = 32'd0;
   logic [31:0] target_jalr = 32'd0;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        is_flushed;
   logic        misalign_err;
   logic [31:0] bad_target;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        en;
      logic        valid;
      logic [31:0] pc;
      logic        chk_id;
      logic [31:0] cnt;
      logic        merr;
      logic [31:0] bad;
   } exp_t;

   exp_t sb_q[$];

   fetch_pc_unit #(
      .RESET_PC(32'h0000_0000),
      .TRAP_PC (32'h0000_0100),
      .NOP     (c_NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .PC_sel       (PC_sel),
      .flush        (flush),
      .target_branch(target_branch),
      .target_jal   (target_jal),
      .target_jalr  (target_jalr),
      .imem_addr    (imem_addr),
      .imem_en      (imem_en),
      .imem_rdata   (imem_rdata),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_pc4       (id_pc4),
      .is_flushed   (is_flushed),
      .misalign_err (misalign_err),
      .bad_target   (bad_target),
      .fetch_count  (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_0000;
   endfunction

   // Synchronous instruction memory that holds its output while disabled.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem_word(imem_addr);
   end

   task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s actual=%h expected=%h", n, f, act, exp);
      end
   endtask

   // Monitor: the ID slot and fetch port are presented every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp(e.name, "imem_addr", imem_addr, e.addr);
            cmp(e.name, "imem_en", {31'd0, imem_en}, {31'd0, e.en});
            cmp(e.name, "is_flushed", {31'd0, is_flushed}, {31'd0, ~e.valid});
            cmp(e.name, "id_instr", id_instr, e.valid ? mem_word(e.pc) : c_NOP);
            if (e.chk_id) begin
               cmp(e.name, "id_pc", id_pc, e.pc);
               cmp(e.name, "id_pc4", id_pc4, e.pc + 32'd4);
            end
            cmp(e.name, "fetch_count", fetch_count, e.cnt);
            cmp(e.name, "misalign_err", {31'd0, misalign_err}, {31'd0, e.merr});
            cmp(e.name, "bad_target", bad_target, e.bad);
         end
      end
   end

   function automatic exp_t mk(input string n, input logic [31:0] addr, input logic en,
                               input logic valid, input logic [31:0] pc, input logic chk_id,
                               input logic [31:0] cnt, input logic merr, input logic [31:0] bad);
      exp_t e;
      e.name = n; e.addr = addr; e.en = en; e.valid = valid; e.pc = pc;
      e.chk_id = chk_id; e.cnt = cnt; e.merr = merr; e.bad = bad;
      return e;
   endfunction

   task automatic step(input logic r, input logic s, input logic f, input logic [1:0] sel,
                       input logic [31:0] tgt, input exp_t e);
      @(negedge clk);
      #1;
      rst = r; stall = s; flush = f; PC_sel = sel;
      target_branch = tgt; target_jal = tgt; target_jalr = tgt;
      @(posedge clk);
      #1;
      sb_q.push_back(e);
   endtask

   initial begin
      // reset                 addr          en  vld pc            chk cnt merr bad
      step(1, 0, 0, 2'b00, 0, mk("reset0", 32'h0, 0, 0, 32'h0, 1, 0, 0, 0));
      step(1, 0, 0, 2'b00, 0, mk("reset1", 32'h0, 0, 0, 32'h0, 1, 0, 0, 0));
      // free running
      step(0, 0, 0, 2'b00, 0, mk("run_pc0", 32'h4, 1, 1, 32'h0, 1, 0, 0, 0));
      step(0, 0, 0, 2'b00, 0, mk("run_pc4", 32'h8, 1, 1, 32'h4, 1, 1, 0, 0));
      step(0, 0, 0, 2'b00, 0, mk("run_pc8", 32'hC, 1, 1, 32'h8, 1, 2, 0, 0));
      // stall with PC 8 in ID
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 2'b00, 0, mk("stall", 32'hC, 0, 1, 32'h8, 1, 2, 0, 0));
      step(0, 0, 0, 2'b00, 0, mk("resume", 32'h10, 1, 1, 32'hC, 1, 3, 0, 0));
      // branch flush overriding stall
      step(0, 1, 1, 2'b01, 32'h40, mk("br_flush", 32'h40, 1, 0, 32'h10, 1, 3, 0, 0));
      step(0, 0, 0, 2'b00, 0, mk("br_target", 32'h44, 1, 1, 32'h40, 1, 3, 0, 0));
      // JALR clears bit 0
      step(0, 0, 1, 2'b11, 32'h81, mk("jalr_flush", 32'h80, 1, 0, 32'h44, 1, 3, 0, 0));
      step(0, 0, 0, 2'b00, 0, mk("jalr_target", 32'h84, 1, 1, 32'h80, 1, 3, 0, 0));
      // misaligned JAL, then a second misalignment keeps the first bad_target
      step(0, 0, 1, 2'b10, 32'h22, mk("jal_mis1", 32'h100, 1, 0, 32'h0, 0, 3, 1, 32'h22));
      step(0, 0, 1, 2'b10, 32'h36, mk("jal_mis2", 32'h100, 1, 0, 32'h0, 0, 3, 1, 32'h22));
      // PC_sel ignored without flush
      step(0, 0, 0, 2'b01, 32'h200, mk("sel_nofl", 32'h104, 1, 1, 32'h100, 1, 3, 1, 32'h22));
      // sequential flush still squashes
      step(0, 0, 1, 2'b00, 0, mk("seq_flush", 32'h108, 1, 0, 32'h104, 1, 3, 1, 32'h22));
      // address wrap
      step(0, 0, 1, 2'b01, 32'hFFFF_FFFC, mk("to_top", 32'hFFFF_FFFC, 1, 0, 32'h108, 1, 3, 1, 32'h22));
      step(0, 0, 0, 2'b00, 0, mk("wrap", 32'h0, 1, 1, 32'hFFFF_FFFC, 1, 3, 1, 32'h22));
      step(0, 0, 0, 2'b00, 0, mk("post_wrap", 32'h4, 1, 1, 32'h0, 1, 4, 1, 32'h22));
      // reset wins over stall and flush
      step(1, 1, 1, 2'b01, 32'h40, mk("rst_mid", 32'h0, 0, 0, 32'h0, 1, 0, 0, 0));
      step(0, 0, 0, 2'b00, 0, mk("after_rst", 32'h4, 1, 1, 32'h0, 1, 0, 0, 0));

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage and PC register for the RV32I core. It consumes the `PC_sel` and `flush` decisions made in EX and selects the next fetch address. It drives a synchronous (1-cycle read latency) instruction memory and presents the fetched word to ID. It also produces the `is_flushed` bubble marker that travels with each slot down the pipe and suppresses control decisions for squashed instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_PC`, default 32'h0000_0100: fetch address after a misaligned redirect.
- `NOP`, default 32'h0000_0013 (`addi x0,x0,0`): instruction presented to ID for bubbles.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hazard unit request to hold IF and ID.
- `PC_sel`  in  2  next-PC select from EX: 00 seq, 01 branch, 10 JAL, 11 JALR.
- `flush`  in  1  EX redirect request; squashes the wrong-path slot.
- `target_branch`  in  32  PC_EX + B-imm.
- `target_jal`  in  32  PC_EX + J-imm.
- `target_jalr`  in  32  rs1 + I-imm, unmasked.
- `imem_addr`  out  32  fetch address, equal to `pc_q`.
- `imem_en`  out  1  memory read enable; memory holds `imem_rdata` when low.
- `imem_rdata`  in  32  word for the address presented on the previous enabled edge.
- `id_instr`  out  32  instruction to ID.
- `id_pc`  out  32  PC of `id_instr`.
- `id_pc4`  out  32  `id_pc + 4`, used by JAL/JALR writeback.
- `is_flushed`  out  1  1 = the ID slot is a bubble.
- `misalign_err`  out  1  sticky; set on a redirect to a non-word-aligned target.
- `bad_target`  out  32  offending target, captured on the first misalignment only.
- `fetch_count`  out  32  count of valid instructions accepted by ID.

## Operation
- Registers:
  - `pc_q`: address in flight.
  - `fpc_q`, `fvalid_q`: PC and validity of the word now on `imem_rdata`.
  - `misalign_err`, `bad_target`, `fetch_count`.
- ID outputs are combinational from registers:
  - `id_instr = fvalid_q ? imem_rdata : NOP`.
  - `id_pc = fpc_q`.
  - `id_pc4 = fpc_q + 4`, mod 2^32.
  - `is_flushed = ~fvalid_q`.
- `imem_en = ~rst & (~stall | flush)`.
- Redirect target `T`, used only when `flush=1`:
  - 01: `target_branch`.
  - 10: `target_jal`.
  - 11: `{target_jalr[31:1],1'b0}`.
  - 00: `pc_q+4` (sequential, but the slot is still squashed).
- Priority at each edge, highest first:
  1. `rst`.
  2. `flush`: overrides `stall`.
  3. `stall`.
  4. Normal advance.
- Edge update for each case:
  - flush, `T[1:0]==0`: `pc_q<=T`; `fvalid_q<=0`; `fpc_q<=pc_q`.
  - flush, `T[1:0]!=0`: `pc_q<=TRAP_PC`; `fvalid_q<=0`; `misalign_err<=1`; `bad_target<=T` if `misalign_err` was 0.
  - stall, no flush: all registers hold; `imem_en=0`, so `imem_rdata` holds too.
  - normal: `fpc_q<=pc_q`; `fvalid_q<=1`; `pc_q<=pc_q+4`, wrapping 32'hFFFF_FFFC -> 0.
- `flush=0` with `PC_sel!=00`: `PC_sel` is ignored and the unit advances sequentially.
- `fetch_count` increments, wrapping, on any edge with `fvalid_q & ~stall & ~flush & ~rst`.
- `misalign_err` clears only on `rst`.

## Timing
- Reset values:
  - `pc_q=RESET_PC`, so `imem_addr=RESET_PC`.
  - `fpc_q=0`, `fvalid_q=0`, so `is_flushed=1`, `id_instr=NOP`, `id_pc=0`, `id_pc4=4`.
  - `misalign_err=0`, `bad_target=0`, `fetch_count=0`.
  - `imem_en=0` while `rst` is high.
- First valid ID slot: the second cycle after `rst` deasserts; it holds `id_pc=RESET_PC`.
- Fetch latency: an address in `pc_q` at edge n appears on ID after edge n+1.
- Redirect penalty: the flush edge inserts exactly one bubble into ID. The target instruction reaches ID one cycle after the bubble.
- `rst` mid-stall or mid-flush: `rst` wins and all state returns to reset values at that edge.

## Test plan
- Reset then 4 free-running cycles, `RESET_PC=0` -> ID sees a bubble, then PCs 0, 4, 8; `fetch_count=2` after the edge that accepts PC 4.
- `stall=1` for 3 cycles with PC 8 in ID -> `id_pc=8`, `imem_en=0`, `fetch_count` frozen; sequence resumes with 12 after release.
- `flush=1`, `PC_sel=01`, `target_branch=0x40` while `stall=1` -> next cycle `is_flushed=1`, `imem_addr=0x40`; the following cycle `id_pc=0x40`.
- `flush=1`, `PC_sel=11`, `target_jalr=0x81` -> `imem_addr=0x80`, `misalign_err=0`.
- `flush=1`, `PC_sel=10`, `target_jal=0x22`, followed by a second misaligned flush to 0x36 -> `imem_addr=TRAP_PC`, `misalign_err=1`, `bad_target=0x22` retained.
- `pc_q=0xFFFF_FFFC` free-running -> next `imem_addr=0`, and the ID slot for 0xFFFF_FFFC shows `id_pc4=0`.
